// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle sequencing controller for an RV32I datapath. The opcode is
// latched in FETCH, and a Moore FSM then steps through FETCH, DECODE, EXEC,
// MEM and WB. The block drives the datapath enables and a PC-update strobe.
// Data-memory accesses use a mem_ready handshake with a timeout that traps.
// ALU_CC generation lives in the ALU controller; this block only sequences.
//
// Parameters
//   MEM_TIMEOUT : consecutive mem_ready-low MEM cycles before trapping (1..255)
//   RET_W       : width of the retired-instruction counter
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   opcode     in   [6:0] Instr[6:0], valid during FETCH
//   mem_ready  in   data-memory completion, looked at only in MEM
//   pc_en      out  PC load enable (instruction retires this cycle)
//   ir_en      out  high in FETCH; the opcode is captured on this edge
//   RegWrite   out  register-file write enable
//   MemtoReg   out  write-back mux select (1 = ReadData)
//   ALUsrc     out  ALU B-operand mux select (1 = ExtImm)
//   MemWrite   out  data-memory write enable
//   MemRead    out  data-memory read enable
//   Branch     out  branch qualify, ANDed with ALUZero in the datapath
//   trap       out  high while in TRAP
//   trap_cause out  [1:0] 00 none, 01 illegal opcode, 10 memory timeout
//   state      out  [2:0] FSM state encoding, for debug
//   retired    out  [RET_W-1:0] completed-instruction count, wraps
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_en,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUsrc,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             Branch,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);

  // --------------------------------------------------------------------------
  // State encoding. Kept as plain 3-bit codes rather than an enum so the two
  // unused codes (6, 7) remain representable and can be recovered from.
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // RV32I major opcodes handled by this controller.
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

  // Wait-counter value seen in the last permitted mem_ready-low MEM cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    CL_R,
    CL_I_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ILLEGAL
  } op_class_t;

  // --------------------------------------------------------------------------
  // Registers and internal wires
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [6:0]       r_opcode;
  logic [7:0]       r_wait;
  logic [RET_W-1:0] r_retired;
  logic [1:0]       r_trap_cause;

  logic [2:0]       w_next_state;
  op_class_t        w_class;
  logic             w_mem_timeout;
  logic             w_illegal_trap;

  // --------------------------------------------------------------------------
  // Opcode classification of the latched instruction
  // --------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_class = CL_ILLEGAL;
    case (r_opcode)
      OPC_R:      w_class = CL_R;
      OPC_I_ALU:  w_class = CL_I_ALU;
      OPC_LOAD:   w_class = CL_LOAD;
      OPC_STORE:  w_class = CL_STORE;
      OPC_BRANCH: w_class = CL_BRANCH;
      default:    w_class = CL_ILLEGAL;
    endcase
  end

  // Trap events, shared by the next-state logic and the cause register.
  assign w_illegal_trap = (r_state == ST_DECODE) && (w_class == CL_ILLEGAL);
  assign w_mem_timeout  = (r_state == ST_MEM) && !mem_ready && (r_wait == WAIT_LAST);

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH: begin
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        w_next_state = w_illegal_trap ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (w_class)
          CL_BRANCH:          w_next_state = ST_FETCH;
          CL_R, CL_I_ALU:     w_next_state = ST_WB;
          CL_LOAD, CL_STORE:  w_next_state = ST_MEM;
          default:            w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          w_next_state = (w_class == CL_LOAD) ? ST_WB : ST_FETCH;
        end else if (w_mem_timeout) begin
          w_next_state = ST_TRAP;
        end else begin
          w_next_state = ST_MEM;
        end
      end
      ST_WB: begin
        w_next_state = ST_FETCH;
      end
      ST_TRAP: begin
        // Sticky until reset; opcode and mem_ready are ignored here.
        w_next_state = ST_TRAP;
      end
      default: begin
        // Codes 6 and 7 are unreachable; recover to FETCH if ever entered.
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs, decoded from state and latched opcode.
  // The store-completion strobe in MEM is the one output qualified by an
  // input: a store whose mem_ready is already high on MEM entry must retire
  // in that very cycle (w = 0), so pc_en there follows mem_ready.
  // Reset forces every enable, ir_en and trap low, which also suppresses a
  // MemWrite that would otherwise be issued in the reset-asserted cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUsrc   = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Branch   = 1'b0;
    trap     = 1'b0;

    case (r_state)
      ST_FETCH: begin
        ir_en = 1'b1;
      end
      ST_DECODE: begin
        // All enables idle while the opcode is classified.
      end
      ST_EXEC: begin
        ALUsrc = (w_class == CL_I_ALU) || (w_class == CL_LOAD) ||
                 (w_class == CL_STORE);
        if (w_class == CL_BRANCH) begin
          Branch = 1'b1;
          pc_en  = 1'b1;
        end
      end
      ST_MEM: begin
        // Address stays ExtImm-based and the strobe is held until exit.
        ALUsrc   = 1'b1;
        MemRead  = (w_class == CL_LOAD);
        MemWrite = (w_class == CL_STORE);
        pc_en    = (w_class == CL_STORE) && mem_ready;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        MemtoReg = (w_class == CL_LOAD);
        ALUsrc   = (w_class == CL_I_ALU) || (w_class == CL_LOAD);
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        // Unreachable codes drive nothing.
      end
    endcase

    if (reset) begin
      pc_en    = 1'b0;
      ir_en    = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      ALUsrc   = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      Branch   = 1'b0;
      trap     = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Opcode latch, MEM wait counter, retire counter and trap cause
  // --------------------------------------------------------------------------
  // NOTE: all control registers here are reset, since the sequencing and the
  // trap/retire bookkeeping must start from known values after every reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode     <= 7'd0;
      r_wait       <= 8'd0;
      r_retired    <= '0;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      if (r_state == ST_FETCH) begin
        r_opcode <= opcode;
      end

      // Cleared on the way into MEM, counts mem_ready-low cycles while there.
      if (r_state == ST_EXEC) begin
        r_wait <= 8'd0;
      end else if ((r_state == ST_MEM) && !mem_ready) begin
        r_wait <= r_wait + 8'd1;
      end

      // Every pc_en marks a completed instruction; wraps without a flag.
      if (pc_en) begin
        r_retired <= r_retired + RET_W'(1);
      end

      if (w_illegal_trap) begin
        r_trap_cause <= CAUSE_ILLEGAL;
      end else if (w_mem_timeout) begin
        r_trap_cause <= CAUSE_MEM_TO;
      end
    end
  end

  assign state      = r_state;
  assign retired    = r_retired;
  assign trap_cause = r_trap_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4, RET_W = 4).
// The driver applies one cycle of stimulus at a time and pushes the outputs
// that cycle should show into a queue; a negedge monitor pops and compares.
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TO    = 4;
  localparam int RET_W = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JUNK = 7'b1111111;

  logic             clk;
  logic             reset;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_en, ir_en, RegWrite, MemtoReg, ALUsrc;
  logic             MemWrite, MemRead, Branch, trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [RET_W-1:0] retired;

  multicycle_ctrl #(
    .MEM_TIMEOUT(TO),
    .RET_W      (RET_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .ir_en     (ir_en),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .ALUsrc    (ALUsrc),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Branch    (Branch),
    .trap      (trap),
    .trap_cause(trap_cause),
    .state     (state),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0]      vec;
    logic [RET_W-1:0] ret;
    string            tag;
  } exp_t;

  exp_t q_exp[$];

  int n_total = 0;
  int n_bad   = 0;

  // Bench-side view of where the controller should be between instructions.
  logic [2:0]       m_state;
  logic [1:0]       m_cause;
  logic [RET_W-1:0] m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packs one cycle's expected outputs in the same order the monitor samples.
  function automatic logic [13:0] ev(input logic [2:0] st, input logic pc, input logic ir,
                                     input logic rw, input logic m2r, input logic als,
                                     input logic mw, input logic mr, input logic br,
                                     input logic tr, input logic [1:0] cs);
    return {st, pc, ir, rw, m2r, als, mw, mr, br, tr, cs};
  endfunction

  // One clock of stimulus plus the outputs expected during that clock.
  task automatic step(input logic rst, input logic [6:0] op, input logic rdy,
                      input logic [13:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    x.vec = e;
    x.ret = m_ret;
    x.tag = tag;
    q_exp.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      check({e.tag, "/outs"},
            32'({state, pc_en, ir_en, RegWrite, MemtoReg, ALUsrc, MemWrite,
                 MemRead, Branch, trap, trap_cause}),
            32'(e.vec));
      check({e.tag, "/retired"}, 32'(retired), 32'(e.ret));
    end
  end

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 7'($urandom), 1'($urandom),
           ev(m_state, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_cause), "reset");
      m_state = 3'd0;
      m_cause = 2'b00;
      m_ret   = '0;
    end
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 7'($urandom), 1'($urandom),
           ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 1, m_cause), "trap_hold");
    end
  endtask

  // One instruction: w = mem_ready-low MEM cycles before ready (large = stuck),
  // rst_at = MEM cycle index in which reset is asserted (-1 = never).
  // Outside FETCH the opcode bus carries junk and, outside MEM, mem_ready is
  // high, so a design using the live opcode or pre-arming on ready is caught.
  task automatic run_instr(input logic [6:0] op, input int w, input int rst_at);
    logic is_r, is_i, is_ld, is_st, is_br;
    is_r  = (op == OP_R);
    is_i  = (op == OP_I);
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    is_br = (op == OP_BR);

    step(1'b0, op, 1'b1, ev(3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, m_cause), "fetch");
    step(1'b0, OP_JUNK, 1'b1, ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_cause), "decode");
    if (!(is_r || is_i || is_ld || is_st || is_br)) begin
      m_state = 3'd5;
      m_cause = 2'b01;
      return;
    end

    if (is_br) begin
      step(1'b0, OP_JUNK, 1'b1, ev(3'd2, 1, 0, 0, 0, 0, 0, 0, 1, 0, m_cause), "exec_br");
      m_ret++;
      m_state = 3'd0;
      return;
    end

    step(1'b0, OP_JUNK, 1'b1,
         ev(3'd2, 0, 0, 0, 0, is_i | is_ld | is_st, 0, 0, 0, 0, m_cause), "exec");

    if (is_r || is_i) begin
      step(1'b0, OP_JUNK, 1'b1, ev(3'd4, 1, 0, 1, 0, is_i, 0, 0, 0, 0, m_cause), "wb_alu");
      m_ret++;
      m_state = 3'd0;
      return;
    end

    for (int k = 0; k < 300; k++) begin
      if (k == rst_at) begin
        step(1'b1, OP_JUNK, 1'b0, ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_cause), "mem_reset");
        m_ret   = '0;
        m_cause = 2'b00;
        m_state = 3'd0;
        return;
      end
      if (k < w) begin
        step(1'b0, OP_JUNK, 1'b0, ev(3'd3, 0, 0, 0, 0, 1, is_st, is_ld, 0, 0, m_cause), "mem_wait");
        if (k == TO - 1) begin
          m_cause = 2'b10;
          m_state = 3'd5;
          return;
        end
      end else if (is_st) begin
        step(1'b0, OP_JUNK, 1'b1, ev(3'd3, 1, 0, 0, 0, 1, 1, 0, 0, 0, m_cause), "mem_st_done");
        m_ret++;
        m_state = 3'd0;
        return;
      end else begin
        step(1'b0, OP_JUNK, 1'b1, ev(3'd3, 0, 0, 0, 0, 1, 0, 1, 0, 0, m_cause), "mem_ld_done");
        step(1'b0, OP_JUNK, 1'b0, ev(3'd4, 1, 0, 1, 1, 1, 0, 0, 0, 0, m_cause), "wb_load");
        m_ret++;
        m_state = 3'd0;
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    m_state   = 3'd0;
    m_cause   = 2'b00;
    m_ret     = '0;

    rst_cycles(2);

    run_instr(OP_R,  0, -1);          // 0,1,2,4 then FETCH, retired 1
    run_instr(OP_LD, 3, -1);          // 4 MEM cycles, pc_en on cycle 8
    run_instr(OP_ST, 0, -1);          // ready on MEM entry, w = 0
    run_instr(OP_BR, 0, -1);          // pc_en in EXEC
    run_instr(OP_I,  0, -1);          // ALUsrc through WB
    run_instr(OP_ST, 2, -1);
    run_instr(OP_LD, 1000, -1);       // stuck: times out after TO MEM cycles
    trap_hold(20);
    rst_cycles(1);

    run_instr(OP_R, 0, -1);
    run_instr(OP_JUNK, 0, -1);        // illegal: trap, cause 01, retired kept
    trap_hold(3);
    rst_cycles(1);

    run_instr(OP_R, 0, -1);
    run_instr(OP_I, 0, -1);
    run_instr(OP_ST, 100, 1);         // reset in 2nd MEM wait cycle
    run_instr(OP_R, 0, -1);           // FETCH shows retired = 0

    for (int i = 0; i < 18; i++) begin
      run_instr(OP_BR, 0, -1);        // retired wraps 15 -> 0
    end
    run_instr(OP_LD, 0, -1);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
